// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with tick-based debounce.
// One column is driven low at a time; rows are sampled only on scan ticks.
// A key is accepted after DEBOUNCE_N consistent ticks and released after
// DEBOUNCE_N consecutive all-high ticks. num holds the last accepted code.
module keypad_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] num,
  output logic       kphit
);

  localparam int DW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_N + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_PRE   = CW'(DEBOUNCE_N - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [DW-1:0]   div_cnt_r;
  logic [CW-1:0]   match_cnt_r;
  logic [CW-1:0]   rel_cnt_r;
  logic [3:0]      col_r;
  logic [3:0]      num_r;
  logic            kphit_r;
  logic [1:0]      cand_row_r;
  logic [3:0]      cand_code_r;

  logic            tick_s;
  logic            row_any_s;
  logic [1:0]      row_idx_s;
  logic [1:0]      col_idx_s;
  logic            same_row_s;
  logic [3:0]      key_code_s;
  logic [3:0]      col_next_s;

  // Key legend: rows 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd10;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd11;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd12;
      4'd12:   code = 4'd14;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'd15;
      4'd15:   code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // Lowest-numbered low row wins when several rows are pulled low.
  always_comb begin
    row_idx_s = 2'd0;
    if (!row[0]) begin
      row_idx_s = 2'd0;
    end else if (!row[1]) begin
      row_idx_s = 2'd1;
    end else if (!row[2]) begin
      row_idx_s = 2'd2;
    end else if (!row[3]) begin
      row_idx_s = 2'd3;
    end else begin
      row_idx_s = 2'd0;
    end
  end

  // Column index of the currently driven (low) column.
  always_comb begin
    case (col_r)
      4'b1110: col_idx_s = 2'd0;
      4'b1101: col_idx_s = 2'd1;
      4'b1011: col_idx_s = 2'd2;
      4'b0111: col_idx_s = 2'd3;
      default: col_idx_s = 2'd0;
    endcase
  end

  assign tick_s     = (div_cnt_r == DIV_LAST);
  assign row_any_s  = (row != 4'b1111);
  assign same_row_s = row_any_s && (row_idx_s == cand_row_r);
  assign key_code_s = key_code(row_idx_s, col_idx_s);
  assign col_next_s = {col_r[2:0], col_r[3]};

  assign col   = col_r;
  assign num   = num_r;
  assign kphit = kphit_r;

  // Scan-tick divider: one-cycle tick at SCAN_DIV-1, then wrap to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

  // Scan / debounce / hold / release state machine; acts only on ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SCAN;
      col_r       <= 4'b1110;
      num_r       <= 4'd0;
      kphit_r     <= 1'b0;
      match_cnt_r <= '0;
      rel_cnt_r   <= '0;
      cand_row_r  <= 2'd0;
      cand_code_r <= 4'd0;
    end else if (tick_s) begin
      case (state_r)
        SCAN: begin
          if (!row_any_s) begin
            col_r <= col_next_s;
          end else begin
            cand_row_r  <= row_idx_s;
            cand_code_r <= key_code_s;
            match_cnt_r <= CW'(1);
            if (DEBOUNCE_N == 1) begin
              state_r <= PRESSED;
              num_r   <= key_code_s;
              kphit_r <= 1'b1;
            end else begin
              state_r <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (same_row_s) begin
            match_cnt_r <= match_cnt_r + CW'(1);
            if (match_cnt_r == DB_PRE) begin
              state_r <= PRESSED;
              num_r   <= cand_code_r;
              kphit_r <= 1'b1;
            end
          end else begin
            state_r <= SCAN;
            col_r   <= col_next_s;
          end
        end
        PRESSED: begin
          if (!row_any_s) begin
            if (DEBOUNCE_N == 1) begin
              state_r <= SCAN;
              kphit_r <= 1'b0;
              col_r   <= col_next_s;
            end else begin
              rel_cnt_r <= CW'(1);
              state_r   <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!row_any_s) begin
            rel_cnt_r <= rel_cnt_r + CW'(1);
            if (rel_cnt_r == DB_PRE) begin
              state_r <= SCAN;
              kphit_r <= 1'b0;
              col_r   <= col_next_s;
            end
          end else begin
            state_r <= PRESSED;
          end
        end
        default: begin
          state_r <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized keypad stimulus checked every cycle against a
// behavioural model of the scanner, plus a few directed scenarios.
module tb_keypad_scan;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 3;

  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_PRS  = 2;
  localparam int M_REL  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row = 4'b1111;
  logic [3:0] col;
  logic [3:0] num;
  logic       kphit;

  // Pressed keys of the physical keypad, bit index = row*4 + column.
  logic [15:0] keys = 16'd0;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state.
  int m_n = 0;
  int m_mode = M_SCAN;
  int m_idx = 0;
  int m_code = 0;
  int m_hit = 0;
  int m_cand_row = 0;
  int m_cand_code = 0;
  int m_mc = 0;
  int m_rc = 0;
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_N(DEBOUNCE_N)) dut (
    .clk   (clk),
    .reset (reset),
    .row   (row),
    .col   (col),
    .num   (num),
    .kphit (kphit)
  );

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Passive matrix: a row reads low if any pressed key sits in the driven column.
  function automatic logic [3:0] pad_rows(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = ((k[i*4 +: 4] & ~c) == 4'b0000);
    end
    return r;
  endfunction

  task automatic advance_col();
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] rw);
    int lr;
    bit tick;
    if (rst) begin
      m_n = 0; m_mode = M_SCAN; m_idx = 0; m_code = 0; m_hit = 0;
      m_mc = 0; m_rc = 0;
    end else begin
      tick = ((m_n % SCAN_DIV) == SCAN_DIV - 1);
      m_n++;
      if (tick) begin
        lr = -1;
        for (int r = 3; r >= 0; r--) if (!rw[r]) lr = r;
        case (m_mode)
          M_SCAN: begin
            if (lr < 0) advance_col();
            else begin
              m_cand_row = lr;
              m_cand_code = keymap[lr*4 + m_idx];
              m_mc = 1;
              if (DEBOUNCE_N == 1) begin
                m_mode = M_PRS; m_code = m_cand_code; m_hit = 1;
              end else m_mode = M_DEB;
            end
          end
          M_DEB: begin
            if (lr == m_cand_row) begin
              m_mc++;
              if (m_mc == DEBOUNCE_N) begin
                m_mode = M_PRS; m_code = m_cand_code; m_hit = 1;
              end
            end else begin
              m_mode = M_SCAN; advance_col();
            end
          end
          M_PRS: begin
            if (lr < 0) begin
              if (DEBOUNCE_N == 1) begin
                m_mode = M_SCAN; m_hit = 0; advance_col();
              end else begin
                m_rc = 1; m_mode = M_REL;
              end
            end
          end
          default: begin
            if (lr < 0) begin
              m_rc++;
              if (m_rc == DEBOUNCE_N) begin
                m_mode = M_SCAN; m_hit = 0; advance_col();
              end
            end else m_mode = M_PRS;
          end
        endcase
      end
    end
  endtask

  // One clock: drive inputs, advance model, compare after the falling edge.
  task automatic cycle(input logic rst);
    logic [3:0] exp_col;
    reset = rst;
    row = pad_rows(keys, col);
    model_step(rst, row);
    @(posedge clk);
    @(negedge clk);
    exp_col = 4'b1111 ^ (4'b0001 << m_idx);
    check("col", col, exp_col);
    check("num", num, 4'(m_code));
    check("kphit", {3'b000, kphit}, {3'b000, 1'(m_hit)});
  endtask

  initial begin
    logic [15:0] k;
    int len;
    bit bounced;
    bit seen_hit;

    // Reset, then idle scanning.
    cycle(1'b1);
    cycle(1'b1);
    check("rst_col", col, 4'b1110);
    check("rst_num", num, 4'd0);
    check("rst_kphit", {3'b000, kphit}, 4'd0);
    for (int i = 0; i < 32; i++) cycle(1'b0);

    // Hold key 5 (row1, col1) until accepted.
    keys = 16'd1 << 5;
    for (int i = 0; i < 60; i++) cycle(1'b0);
    check("key5_num", num, 4'd5);
    check("key5_hit", {3'b000, kphit}, 4'd1);
    check("key5_col", col, 4'b1101);

    // Release: num retained, kphit cleared.
    keys = 16'd0;
    for (int i = 0; i < 40; i++) cycle(1'b0);
    check("rel_num", num, 4'd5);
    check("rel_hit", {3'b000, kphit}, 4'd0);

    // Bounce: key B visible on a single detection tick only.
    bounced = 1'b0;
    seen_hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!bounced && col == 4'b0111 && (m_n % SCAN_DIV) == SCAN_DIV - 1) begin
        keys = 16'd1 << 7;
        bounced = 1'b1;
      end else begin
        keys = 16'd0;
      end
      cycle(1'b0);
      if (kphit) seen_hit = 1'b1;
    end
    check("bounce_done", {3'b000, bounced}, 4'd1);
    check("bounce_hit", {3'b000, seen_hit}, 4'd0);

    // Rows 0 and 2 low in col1: row 0 has priority (key 2).
    keys = (16'd1 << 1) | (16'd1 << 9);
    for (int i = 0; i < 60; i++) cycle(1'b0);
    check("prio_num", num, 4'd2);
    check("prio_hit", {3'b000, kphit}, 4'd1);
    cycle(1'b1);
    check("rst_held_hit", {3'b000, kphit}, 4'd0);
    check("rst_held_num", num, 4'd0);
    check("rst_held_col", col, 4'b1110);
    keys = 16'd0;
    for (int i = 0; i < 8; i++) cycle(1'b0);

    // Random presses, noisy contacts, key changes and occasional resets.
    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(1, 2);
        for (int i = 0; i < len; i++) cycle(1'b1);
      end
      k = 16'd1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) k = k | (16'd1 << $urandom_range(0, 15));
      len = $urandom_range(8, 60);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) k = 16'd1 << $urandom_range(0, 15);
        keys = ($urandom_range(0, 5) == 0) ? 16'd0 : k;
        if ($urandom_range(0, 49) == 0) begin
          cycle(1'b1);
        end else begin
          cycle(1'b0);
        end
      end
      len = $urandom_range(4, 40);
      for (int i = 0; i < len; i++) begin
        keys = ($urandom_range(0, 15) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0;
        cycle(1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
